sk6812_refresh_sequencer: RTL and testbench
===========================================

SK6812_REFRESH_SEQUENCER -- requirements
Module: sk6812_refresh_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_0000, byte base address of the LED peripheral slave.
REQ-002 SHALL have parameter PERIOD_W, default 24, width of the refresh-period counter.
REQ-003 SHALL have parameter TMO, default 255, maximum cycles waiting for m_ack_i per bus transaction.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  periodic refresh enable.
REQ-007 start  in  1  one-cycle request for an immediate frame.
REQ-008 n_leds  in  6  LED count per frame (0..63).
REQ-009 period  in  PERIOD_W  cycles between automatic frame starts; 0 = automatic refresh off.
REQ-010 m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone classic master controls.
REQ-011 m_adr_o  out  32  BASE_ADR + register offset.
REQ-012 m_sel_o  out  4  always 4'hF.
REQ-013 m_dat_o  out  32  write data.
REQ-014 m_dat_i  in  32  read data.
REQ-015 m_ack_i  in  1  slave acknowledge.
REQ-016 seq_busy  out  1  high in every state except IDLE.
REQ-017 frame_done  out  1  one-cycle pulse after trigger write acked.
REQ-018 err  out  1  sticky ack-timeout flag.
REQ-019 frame_cnt  out  16  completed frames, wraps 16'hFFFF->0.

Function
REQ-020 FSM states SHALL be IDLE, POLL, WR_NBITS, WR_SRC, WR_TRIG, DONE.
REQ-021 Frame request SHALL be start pulse, or enable=1 with period!=0 and period counter reaching period-1; evaluated only in IDLE; requests outside IDLE dropped.
REQ-022 Period counter SHALL count every cycle while enable=1 and period!=0, clear on frame request and when enable=0.
REQ-023 In IDLE with request and n_leds==0: no bus transaction; counter cleared; frame_cnt and frame_done unchanged.
REQ-024 POLL SHALL read offset 0x000C; on ack with m_dat_i[0]=1 reissue the read after one idle cycle; on m_dat_i[0]=0 go WR_NBITS.
REQ-025 WR_NBITS SHALL write {21'h0, n_leds, 5'h0} (n_leds*32) to offset 0x0000.
REQ-026 WR_SRC SHALL write 32'h1 to offset 0x0008 (RAM source).
REQ-027 WR_TRIG SHALL write 32'h0 to offset 0x0004 (transmission trigger).
REQ-028 n_leds SHALL be sampled into a register on frame request and held for the whole frame.
REQ-029 Each transaction: cyc/stb/we/adr/dat held stable from assertion until the cycle m_ack_i=1 is sampled; deasserted the following cycle; at least one idle cycle between transactions.
REQ-030 DONE SHALL last one cycle: frame_done=1, frame_cnt+1, return IDLE.
REQ-031 Ack not seen within TMO cycles of stb assertion: drop cyc/stb, set err, return IDLE, no frame_done, no frame_cnt increment.
REQ-032 err SHALL clear on a start pulse accepted in IDLE; timeout and clear together -> err=1.
REQ-033 enable deassert mid-frame SHALL not abort the frame in progress.
REQ-034 m_ack_i while cyc/stb low SHALL be ignored.

Reset
REQ-035 On reset: state IDLE, m_cyc_o=m_stb_o=m_we_o=0, m_adr_o=0, m_dat_o=0, m_sel_o=4'hF, seq_busy=0, frame_done=0, err=0, frame_cnt=0, period and timeout counters 0.
REQ-036 Reset mid-transaction SHALL drop cyc/stb immediately (asynchronous), no completion.

Structure
REQ-037 Shared package SHALL hold register offsets (0x0000, 0x0004, 0x0008, 0x000C) and the FSM state enumeration.
REQ-038 One sub-module SHALL be natural: wb_master_xfer (single-transaction Wishbone engine with timeout); FSM and counters in top.

Verification
REQ-039 start, n_leds=8, slave busy=0, ack after 1 cycle -> read 0x000C, writes 0x0000=0x100, 0x0008=0x1, 0x0004=0x0, frame_done pulse, frame_cnt=1.
REQ-040 Slave returns busy=1 three polls then 0 -> four reads of 0x000C before write to 0x0000.
REQ-041 enable=1, period=1000, n_leds=4 -> frame_done pulses roughly every 1000 cycles, frame_cnt increments each time.
REQ-042 Slave never acks write to 0x0008 -> cyc/stb drop after 255 cycles, err=1, no frame_done; next start clears err.
REQ-043 n_leds=0 with start -> no cyc assertion, frame_cnt unchanged; start during active frame ignored.
REQ-044 reset asserted while stb high in WR_NBITS -> cyc/stb low same cycle, all outputs at reset values.

Source files
------------

// File: rtl/sk6812_refresh_sequencer_pkg.sv
// Shared definitions for the SK6812 refresh sequencer: LED peripheral register map
// and sequencer FSM states.
package sk6812_refresh_sequencer_pkg;

   localparam logic [31:0] OfsNbits  = 32'h0000_0000;
   localparam logic [31:0] OfsTrig   = 32'h0000_0004;
   localparam logic [31:0] OfsSrc    = 32'h0000_0008;
   localparam logic [31:0] OfsStatus = 32'h0000_000C;

   typedef enum logic [2:0] {
      StIdle,
      StPoll,
      StWrNbits,
      StWrSrc,
      StWrTrig,
      StDone
   } seq_state_e;

endpackage

// File: rtl/sk6812_refresh_sequencer_if.sv
// Wishbone classic bus between the refresh sequencer (master) and the LED peripheral.
interface sk6812_refresh_sequencer_if;
   logic        m_cyc_o;
   logic        m_stb_o;
   logic        m_we_o;
   logic [31:0] m_adr_o;
   logic [3:0]  m_sel_o;
   logic [31:0] m_dat_o;
   logic [31:0] m_dat_i;
   logic        m_ack_i;

   modport master (
      output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
      input  m_dat_i, m_ack_i
   );

   modport slave (
      input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
      output m_dat_i, m_ack_i
   );
endinterface

// File: rtl/sk6812_refresh_sequencer_wb_master_xfer.sv
// Single-transaction Wishbone classic master: latches a request, holds the bus
// until ack, or gives up after TMO cycles.
module sk6812_refresh_sequencer_wb_master_xfer #(
   parameter int unsigned TMO = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        req_we,
   input  logic [31:0] req_adr,
   input  logic [31:0] req_dat,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] rdata,
   sk6812_refresh_sequencer_if.master wb
);

   localparam int unsigned TmoW = (TMO > 1) ? $clog2(TMO) : 1;

   logic            cyc_q;
   logic            we_q;
   logic [31:0]     adr_q;
   logic [31:0]     dat_q;
   logic [TmoW-1:0] tmo_q;
   logic            ack_ok;

   // Acks outside an active cycle never reach the sequencer.
   assign ack_ok  = cyc_q & wb.m_ack_i;
   assign timeout = cyc_q & ~wb.m_ack_i & (tmo_q == TmoW'(TMO - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
         tmo_q <= '0;
      end else if (!cyc_q) begin
         tmo_q <= '0;
         if (req) begin
            cyc_q <= 1'b1;
            we_q  <= req_we;
            adr_q <= req_adr;
            dat_q <= req_dat;
         end
      end else if (ack_ok || timeout) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   assign wb.m_cyc_o = cyc_q;
   assign wb.m_stb_o = cyc_q;
   assign wb.m_we_o  = we_q;
   assign wb.m_adr_o = adr_q;
   assign wb.m_dat_o = dat_q;
   assign wb.m_sel_o = 4'hF;

   assign busy  = cyc_q;
   assign done  = ack_ok;
   assign rdata = wb.m_dat_i;

endmodule

// File: rtl/sk6812_refresh_sequencer.sv
// Periodic / on-demand SK6812 frame sequencer: polls the LED peripheral status,
// programs bit count and RAM source, then fires the transmission trigger.
module sk6812_refresh_sequencer
   import sk6812_refresh_sequencer_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h0000_0000,
   parameter int unsigned PERIOD_W = 24,
   parameter int unsigned TMO      = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                start,
   input  logic [5:0]          n_leds,
   input  logic [PERIOD_W-1:0] period,
   sk6812_refresh_sequencer_if.master wb,
   output logic                seq_busy,
   output logic                frame_done,
   output logic                err,
   output logic [15:0]         frame_cnt
);

   seq_state_e          state_q, state_d;
   logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
   logic [5:0]          n_leds_q;
   logic                err_q, err_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   logic        auto_hit, frame_req;
   logic        xfer_req, xfer_we, xfer_busy, xfer_done, xfer_tmo;
   logic [31:0] xfer_ofs, xfer_dat, xfer_rdata;
   logic        unused_rdata;

   assign auto_hit     = enable && (period != '0) && (per_cnt_q == period - PERIOD_W'(1));
   assign unused_rdata = ^xfer_rdata[31:1];

   always_comb begin
      state_d   = state_q;
      frame_req = 1'b0;
      xfer_req  = 1'b0;
      xfer_we   = 1'b0;
      xfer_ofs  = OfsStatus;
      xfer_dat  = '0;
      unique case (state_q)
         StIdle: begin
            if (start || auto_hit) begin
               frame_req = 1'b1;
               if (n_leds != 6'd0) state_d = StPoll;
            end
         end
         StPoll: begin
            xfer_req = !xfer_busy;
            // Peripheral still shifting out the previous frame: poll again.
            if (xfer_done && !xfer_rdata[0]) state_d = StWrNbits;
         end
         StWrNbits: begin
            xfer_req = !xfer_busy;
            xfer_we  = 1'b1;
            xfer_ofs = OfsNbits;
            xfer_dat = {21'h0, n_leds_q, 5'h0};
            if (xfer_done) state_d = StWrSrc;
         end
         StWrSrc: begin
            xfer_req = !xfer_busy;
            xfer_we  = 1'b1;
            xfer_ofs = OfsSrc;
            xfer_dat = 32'h1;
            if (xfer_done) state_d = StWrTrig;
         end
         StWrTrig: begin
            xfer_req = !xfer_busy;
            xfer_we  = 1'b1;
            xfer_ofs = OfsTrig;
            if (xfer_done) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (xfer_tmo) state_d = StIdle;

      if (!enable || (period == '0) || frame_req || auto_hit) per_cnt_d = '0;
      else                                                    per_cnt_d = per_cnt_q + 1'b1;

      err_d = err_q;
      if (state_q == StIdle && start) err_d = 1'b0;
      if (xfer_tmo)                   err_d = 1'b1;

      frame_cnt_d = (state_q == StDone) ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         per_cnt_q   <= '0;
         n_leds_q    <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         per_cnt_q   <= per_cnt_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
         if (frame_req) n_leds_q <= n_leds;
      end
   end

   sk6812_refresh_sequencer_wb_master_xfer #(
      .TMO(TMO)
   ) u_xfer (
      .clk     (clk),
      .reset   (reset),
      .req     (xfer_req),
      .req_we  (xfer_we),
      .req_adr (BASE_ADR + xfer_ofs),
      .req_dat (xfer_dat),
      .busy    (xfer_busy),
      .done    (xfer_done),
      .timeout (xfer_tmo),
      .rdata   (xfer_rdata),
      .wb      (wb)
   );

   assign seq_busy   = (state_q != StIdle);
   assign frame_done = (state_q == StDone);
   assign err        = err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sk6812_refresh_sequencer.sv
// Scoreboard bench: stimulus queues expected bus transactions and frame pulses,
// a monitor pops and compares them as the DUT completes them.
module tb_sk6812_refresh_sequencer;

   localparam logic [31:0] Base = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset, enable, start;
   logic [5:0]  n_leds;
   logic [23:0] period;
   logic        seq_busy, frame_done, err;
   logic [15:0] frame_cnt;

   sk6812_refresh_sequencer_if bus ();

   sk6812_refresh_sequencer #(
      .BASE_ADR (Base),
      .PERIOD_W (24),
      .TMO      (255)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start      (start),
      .n_leds     (n_leds),
      .period     (period),
      .wb         (bus),
      .seq_busy   (seq_busy),
      .frame_done (frame_done),
      .err        (err),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_frame;
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_cnt = 0;
   int          cycle_n = 0;

   // Slave model knobs
   int          s_delay = 1;
   int          s_busy_left = 0;
   bit          s_noack_en = 0;
   logic [31:0] s_noack_adr = '0;
   int          s_wait = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   task automatic push_txn(input bit we, input logic [31:0] ofs, input logic [31:0] dat);
      exp_t e;
      e.is_frame = 1'b0;
      e.we       = we;
      e.adr      = Base + ofs;
      e.dat      = dat;
      e.cnt      = '0;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input int polls, input int leds);
      exp_t e;
      for (int i = 0; i <= polls; i++) push_txn(1'b0, 32'h0000_000C, 32'h0);
      push_txn(1'b1, 32'h0000_0000, leds * 32);
      push_txn(1'b1, 32'h0000_0008, 32'h1);
      push_txn(1'b1, 32'h0000_0004, 32'h0);
      e.is_frame = 1'b1;
      e.we       = 1'b0;
      e.adr      = '0;
      e.dat      = '0;
      e.cnt      = exp_cnt[15:0];
      exp_q.push_back(e);
      exp_cnt++;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int n = 0;
      while (seq_busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'h0, seq_busy}, 32'h0);
   endtask

   task automatic wait_stb_adr(input string name, input logic [31:0] adr, input int maxc);
      int n = 0;
      while (!(bus.m_stb_o && bus.m_adr_o == adr) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'h0, bus.m_stb_o}, 32'h1);
   endtask

   task automatic wait_frame_done(input string name, input int maxc, output int at);
      int n = 0;
      while (!frame_done && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'h0, frame_done}, 32'h1);
      at = cycle_n;
      @(negedge clk);
   endtask

   initial forever begin
      @(posedge clk);
      cycle_n++;
   end

   // Wishbone slave: acks after s_delay cycles, reports busy on status reads.
   initial begin
      bus.m_ack_i = 1'b0;
      bus.m_dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!(bus.m_cyc_o && bus.m_stb_o) || bus.m_ack_i) begin
            bus.m_ack_i = 1'b0;
            s_wait      = 0;
         end else if (s_noack_en && bus.m_adr_o == s_noack_adr) begin
            s_wait++;
         end else if (s_wait >= s_delay) begin
            bus.m_ack_i = 1'b1;
            bus.m_dat_i = '0;
            if (bus.m_adr_o == Base + 32'h0000_000C && s_busy_left > 0) begin
               bus.m_dat_i = 32'h1;
               s_busy_left--;
            end
         end else begin
            s_wait++;
         end
      end
   end

   // Monitor: pops the scoreboard on every acked transaction and every frame_done.
   initial begin
      exp_t        e;
      bit          in_txn = 0;
      bit          unstable = 0;
      logic [31:0] cap_adr, cap_dat;
      logic        cap_we;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_txn = 0;
         end else begin
            if (bus.m_cyc_o && bus.m_stb_o) begin
               if (!in_txn) begin
                  in_txn   = 1;
                  unstable = 0;
                  cap_adr  = bus.m_adr_o;
                  cap_dat  = bus.m_dat_o;
                  cap_we   = bus.m_we_o;
               end else if (bus.m_adr_o !== cap_adr || bus.m_dat_o !== cap_dat ||
                            bus.m_we_o !== cap_we) begin
                  unstable = 1;
               end
               if (bus.m_ack_i) begin
                  in_txn = 0;
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_txn: adr 0x%08h we %0d", bus.m_adr_o, bus.m_we_o);
                  end else begin
                     e = exp_q.pop_front();
                     chk("txn_kind", 32'h0, {31'h0, e.is_frame});
                     chk("txn_adr", bus.m_adr_o, e.adr);
                     chk("txn_we", {31'h0, bus.m_we_o}, {31'h0, e.we});
                     if (e.we) chk("txn_dat", bus.m_dat_o, e.dat);
                     chk("txn_sel", {28'h0, bus.m_sel_o}, 32'hF);
                     chk("txn_stable", {31'h0, unstable}, 32'h0);
                  end
               end
            end else begin
               in_txn = 0;
            end
            if (frame_done) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame_done: frame_cnt %0d", frame_cnt);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_kind", 32'h1, {31'h0, e.is_frame});
                  chk("frame_cnt_at_done", {16'h0, frame_cnt}, {16'h0, e.cnt});
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int saw, run;
      int t[3];
      reset  = 1'b1;
      enable = 1'b0;
      start  = 1'b0;
      n_leds = '0;
      period = '0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", {31'h0, bus.m_cyc_o}, 32'h0);
      chk("rst_stb", {31'h0, bus.m_stb_o}, 32'h0);
      chk("rst_we", {31'h0, bus.m_we_o}, 32'h0);
      chk("rst_adr", bus.m_adr_o, 32'h0);
      chk("rst_dat", bus.m_dat_o, 32'h0);
      chk("rst_sel", {28'h0, bus.m_sel_o}, 32'hF);
      chk("rst_busy", {31'h0, seq_busy}, 32'h0);
      chk("rst_done", {31'h0, frame_done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame, 8 LEDs
      push_frame(0, 8);
      n_leds = 6'd8;
      pulse_start();
      wait_idle("frame1_idle", 500);
      chk("frame1_cnt", {16'h0, frame_cnt}, 32'd1);
      chk("frame1_drained", exp_q.size(), 32'd0);

      // Busy for three polls; n_leds changes mid-frame; stray start ignored
      s_busy_left = 3;
      push_frame(3, 5);
      n_leds = 6'd5;
      pulse_start();
      n_leds = 6'd9;
      repeat (3) @(negedge clk);
      chk("frame2_busy_before_stray", {31'h0, seq_busy}, 32'h1);
      pulse_start();
      wait_idle("frame2_idle", 500);
      repeat (5) @(negedge clk);
      chk("frame2_cnt", {16'h0, frame_cnt}, 32'd2);
      chk("frame2_drained", exp_q.size(), 32'd0);

      // Zero LEDs: no bus activity
      n_leds = 6'd0;
      pulse_start();
      saw = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.m_cyc_o) saw = 1;
      end
      chk("zero_no_cyc", saw, 32'd0);
      chk("zero_frame_cnt", {16'h0, frame_cnt}, 32'd2);
      chk("zero_busy", {31'h0, seq_busy}, 32'h0);

      // Ack timeout on the source write
      s_noack_en  = 1'b1;
      s_noack_adr = Base + 32'h0000_0008;
      push_txn(1'b0, 32'h0000_000C, 32'h0);
      push_txn(1'b1, 32'h0000_0000, 32'h0000_0060);
      n_leds = 6'd3;
      pulse_start();
      wait_stb_adr("tmo_src_seen", Base + 32'h0000_0008, 200);
      run = 0;
      while (bus.m_stb_o && run < 400) begin
         run++;
         @(negedge clk);
      end
      chk("tmo_stb_len", run, 32'd255);
      chk("tmo_cyc_low", {31'h0, bus.m_cyc_o}, 32'h0);
      chk("tmo_err", {31'h0, err}, 32'h1);
      chk("tmo_idle", {31'h0, seq_busy}, 32'h0);
      repeat (3) @(negedge clk);
      chk("tmo_frame_cnt", {16'h0, frame_cnt}, 32'd2);
      chk("tmo_drained", exp_q.size(), 32'd0);
      s_noack_en = 1'b0;
      push_frame(0, 1);
      n_leds = 6'd1;
      pulse_start();
      chk("err_cleared_by_start", {31'h0, err}, 32'h0);
      wait_idle("frame3_idle", 500);
      chk("frame3_err", {31'h0, err}, 32'h0);
      chk("frame3_cnt", {16'h0, frame_cnt}, 32'd3);

      // Periodic refresh every 1000 cycles; enable dropped during the third frame
      n_leds = 6'd4;
      period = 24'd1000;
      push_frame(0, 4);
      push_frame(0, 4);
      push_frame(0, 4);
      @(negedge clk);
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            saw = 0;
            while (!seq_busy && saw < 1500) begin
               @(negedge clk);
               saw++;
            end
            enable = 1'b0;
         end
         wait_frame_done("periodic_done", 1500, t[k]);
      end
      chk("period_gap1", t[1] - t[0], 32'd1000);
      chk("period_gap2", t[2] - t[1], 32'd1000);
      repeat (1100) @(negedge clk);
      chk("periodic_cnt", {16'h0, frame_cnt}, 32'd6);
      chk("periodic_drained", exp_q.size(), 32'd0);

      // Reset while the bit-count write is outstanding
      s_noack_en  = 1'b1;
      s_noack_adr = Base + 32'h0000_0000;
      push_txn(1'b0, 32'h0000_000C, 32'h0);
      n_leds = 6'd2;
      pulse_start();
      wait_stb_adr("rst_nbits_seen", Base + 32'h0000_0000, 200);
      chk("rst_nbits_we", {31'h0, bus.m_we_o}, 32'h1);
      chk("rst_nbits_drained", exp_q.size(), 32'd0);
      reset = 1'b1;
      #1;
      chk("midrst_cyc", {31'h0, bus.m_cyc_o}, 32'h0);
      chk("midrst_stb", {31'h0, bus.m_stb_o}, 32'h0);
      chk("midrst_we", {31'h0, bus.m_we_o}, 32'h0);
      chk("midrst_adr", bus.m_adr_o, 32'h0);
      chk("midrst_dat", bus.m_dat_o, 32'h0);
      chk("midrst_sel", {28'h0, bus.m_sel_o}, 32'hF);
      chk("midrst_busy", {31'h0, seq_busy}, 32'h0);
      chk("midrst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset      = 1'b0;
      s_noack_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_rst_stb", {31'h0, bus.m_stb_o}, 32'h0);
      chk("post_rst_busy", {31'h0, seq_busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
